// File: rtl/tb_sim_ctrl_pkg.sv
// Shared types for the simulation controller slice.
//   st_e    : controller FSM states (reset hold, running, finished)
//   cause_e : sticky done cause codes as reported on done_cause
//   cnt_w() : counter width able to hold values 0..n-1 (minimum 1 bit)
package tb_sim_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } st_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_TOHOST  = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_WDOG    = 2'd3
    } cause_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(n)) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tb_sim_ctrl_rst_gen.sv
// tb_rst_gen: core reset generator.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   start              : pulse, (re)enter reset hold; core_rst_n drops next edge
//   hold_en            : hold counter may advance this cycle
//   core_rst_n         : registered active-low reset to the core
//   release_pls        : high in the last hold cycle; core_rst_n rises next edge
module tb_rst_gen
    import tb_sim_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic start,
    input  logic hold_en,
    output logic core_rst_n,
    output logic release_pls
);

    localparam int unsigned     HC_W    = cnt_w(RST_HOLD);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(RST_HOLD - 1);

    logic [HC_W-1:0] hold_cnt;

    assign release_pls = hold_en && (hold_cnt == HC_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_cnt   <= '0;
            core_rst_n <= 1'b0;
        end else if (start) begin
            hold_cnt   <= '0;
            core_rst_n <= 1'b0;
        end else if (release_pls) begin
            hold_cnt   <= '0;
            core_rst_n <= 1'b1;
        end else if (hold_en) begin
            hold_cnt   <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tb_sim_ctrl.sv
// tb_sim_ctrl: simulation controller for tb_top.
// Drives the core reset (initial hold plus one optional re-reset), counts cycles
// and retired instructions, and ends the run on a tohost write, max-cycle timeout
// or retire watchdog, latching one sticky done cause.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   retire_vld         : one pulse per retired instruction
//   tohost_vld/_data   : pass/fail write; data 1 = pass, else fail code data>>1
//   core_rst_n         : registered active-low reset to the core
//   cycle_cnt          : cycles since sys_rst_n release (never re-reset)
//   instret_cnt        : retires since last core reset release
//   sim_done           : sticky run-finished flag
//   done_cause         : 0 none, 1 tohost, 2 timeout, 3 watchdog
//   fail_code          : tohost_data>>1 on a failing tohost write, else 0
module tb_sim_ctrl
    import tb_sim_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_CYCLES    = 'h800,
    parameter int unsigned RST_HOLD      = 4,
    parameter int unsigned RERESET_CYCLE = 0,
    parameter int unsigned WDOG_CYCLES   = 256
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              retire_vld,
    input  logic              tohost_vld,
    input  logic [DATA_W-1:0] tohost_data,
    output logic              core_rst_n,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt,
    output logic              sim_done,
    output logic [1:0]        done_cause,
    output logic [DATA_W-1:0] fail_code
);

    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RERESET_AT = CNT_W'(RERESET_CYCLE);

    st_e              state_q, state_d;
    cause_e           cause_q, cause_d;
    logic [CNT_W-1:0] instret_d;
    logic [CNT_W-1:0] wdog_cnt, wdog_d;
    logic             rereset_used;
    logic             start_rst;
    logic             hold_en;
    logic             release_pls;
    logic             timeout;
    logic             wdog_trip;
    logic             rereset_hit;

    assign timeout     = (cycle_cnt == TIMEOUT_AT);
    assign wdog_trip   = (WDOG_CYCLES != 0) && (wdog_cnt == WDOG_LAST) && !retire_vld;
    assign rereset_hit = (RERESET_CYCLE != 0) && (cycle_cnt == RERESET_AT) && !rereset_used;
    // Kept outside the FSM block so release_pls (a function of hold_en) does not
    // feed back into the same combinational process.
    assign hold_en     = (state_q == ST_HOLD) && !timeout;

    tb_rst_gen #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_gen (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (start_rst),
        .hold_en     (hold_en),
        .core_rst_n  (core_rst_n),
        .release_pls (release_pls)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = CAUSE_NONE;
        start_rst = 1'b0;
        instret_d = instret_cnt;
        wdog_d    = wdog_cnt;
        case (state_q)
            ST_HOLD: begin
                if (timeout) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_TIMEOUT;
                end else if (release_pls) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tohost_vld) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_TOHOST;
                end else if (timeout) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_TIMEOUT;
                end else if (wdog_trip) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_WDOG;
                end else if (rereset_hit) begin
                    state_d   = ST_HOLD;
                    start_rst = 1'b1;
                    instret_d = '0;
                    wdog_d    = '0;
                end else begin
                    instret_d = instret_cnt + CNT_W'(retire_vld);
                    wdog_d    = retire_vld ? '0 : wdog_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_HOLD;
            cause_q      <= CAUSE_NONE;
            cycle_cnt    <= '0;
            instret_cnt  <= '0;
            wdog_cnt     <= '0;
            rereset_used <= 1'b0;
            sim_done     <= 1'b0;
            fail_code    <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt   <= cycle_cnt + 1'b1;
            instret_cnt <= instret_d;
            wdog_cnt    <= wdog_d;
            if (start_rst) begin
                rereset_used <= 1'b1;
            end
            if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
                sim_done <= 1'b1;
                cause_q  <= cause_d;
                fail_code <= ((cause_d == CAUSE_TOHOST) && (tohost_data != DATA_W'(1)))
                             ? (tohost_data >> 1) : '0;
            end
        end
    end

    assign done_cause = cause_q;

endmodule
